coef_bank_ctrl: RTL

Double-buffered commit controller for the modulator's filter coefficient banks. SPI writes land in the shadow registers (`w_cos_1`, `w_sin_1`, `w_cos_2`, `w_sin_2`, 8 taps × 5 bits each). This block snapshots those registers into a staging buffer one set per cycle and clamps each value. It then swaps the staging buffer into the active bank atomically on the next modulator frame boundary, so the datapath never sees a half-written coefficient set. It sits between the SPI slave and the delta-sigma modulator core.

---
 rtl/coef_pkg.sv | 38 +++
 rtl/coef_clamp.sv | 24 ++
 rtl/coef_bank_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/coef_pkg.sv
// Shared constants, types and helpers for the coefficient bank commit controller.
package coef_pkg;

  // Bank geometry: sets are ordered cos1, sin1, cos2, sin2.
  localparam int N_SETS = 4;
  localparam int N_TAPS = 8;
  localparam int W      = 5;

  // Width of the set index used while capturing.
  localparam int IDX_W = $clog2(N_SETS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SETS - 1);

  // Most-negative code is not allowed in the datapath; it is pulled in by one LSB.
  localparam logic [W-1:0] COEF_MIN   = 5'b10000;
  localparam logic [W-1:0] COEF_CLAMP = 5'b10001;

  typedef logic [N_TAPS-1:0][W-1:0]             coef_set_t;
  typedef logic [N_SETS-1:0][N_TAPS-1:0][W-1:0] coef_bank_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CAPTURE    = 2'd1,
    WAIT_FRAME = 2'd2,
    SWAP       = 2'd3
  } ctrl_state_e;

  // Clamp a single coefficient so the symmetric range -15..+15 is guaranteed.
  function automatic logic [W-1:0] clamp_coef(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v == COEF_MIN) begin
      r = COEF_CLAMP;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/coef_clamp.sv
// Combinational clamp for one coefficient set; flags whether any tap was altered.
module coef_clamp
  import coef_pkg::*;
(
  input  coef_set_t i_set,
  output coef_set_t o_set,
  output logic      o_hit
);

  // Clamp every tap and OR together the per-tap hit indications.
  always_comb begin
    o_set = i_set;
    o_hit = 1'b0;
    for (int k = 0; k < N_TAPS; k++) begin
      o_set[k] = clamp_coef(i_set[k]);
      if (i_set[k] == COEF_MIN) begin
        o_hit = 1'b1;
      end else begin
        o_hit = o_hit;
      end
    end
  end

endmodule

// File: rtl/coef_bank_ctrl.sv
// Double-buffered commit controller: snapshots the SPI shadow coefficients
// into a staging bank one set per cycle (clamped), then swaps staging into
// the active bank on the next modulator frame boundary so the datapath only
// ever sees a complete coefficient set.
module coef_bank_ctrl
  import coef_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  coef_bank_t shadow_coef,
  input  logic       commit_req,
  input  logic       frame_strobe,
  output coef_bank_t active_coef,
  output logic       busy,
  output logic       commit_ack,
  output logic       clamp_flag,
  output logic [7:0] swap_count
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_pending;
  coef_bank_t       r_staging;
  coef_bank_t       r_active;
  logic             r_busy;
  logic             r_ack;
  logic             r_clamp_flag;
  logic [7:0]       r_swap_count;

  logic             w_start_capture;
  logic             w_capture;
  logic             w_do_swap;
  coef_set_t        w_sel_set;
  coef_set_t        w_clamped_set;
  logic             w_clamp_hit;

  // One clamp instance serves all sets; the set under capture is muxed in.
  assign w_sel_set = shadow_coef[r_idx];

  coef_clamp u_clamp (
    .i_set (w_sel_set),
    .o_set (w_clamped_set),
    .o_hit (w_clamp_hit)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic and per-state control strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_start_capture = 1'b0;
    w_capture       = 1'b0;
    w_do_swap       = 1'b0;
    case (r_state)
      IDLE: begin
        // Frame strobes here are deliberately dropped; only a request starts work.
        if (commit_req || r_pending) begin
          w_state_nxt     = CAPTURE;
          w_start_capture = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        w_capture = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = WAIT_FRAME;
        end else begin
          w_state_nxt = CAPTURE;
        end
      end
      WAIT_FRAME: begin
        if (frame_strobe) begin
          w_state_nxt = SWAP;
        end else begin
          w_state_nxt = WAIT_FRAME;
        end
      end
      SWAP: begin
        w_do_swap   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Set index walks 0..N_SETS-1 during capture and wraps back to 0 afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if (w_start_capture) begin
      r_idx <= '0;
    end else if (w_capture) begin
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Staging bank: each capture cycle overwrites exactly one set with its clamped copy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_staging <= '0;
    end else if (w_capture) begin
      r_staging[r_idx] <= w_clamped_set;
    end else begin
      r_staging <= r_staging;
    end
  end

  // One-deep pending request: requests while busy merge; cleared when capture starts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (w_start_capture) begin
      r_pending <= 1'b0;
    end else if (commit_req && (r_state != IDLE)) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Sticky clamp indication, scoped to the most recent capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clamp_flag <= 1'b0;
    end else if (w_start_capture) begin
      r_clamp_flag <= 1'b0;
    end else if (w_capture && w_clamp_hit) begin
      r_clamp_flag <= 1'b1;
    end else begin
      r_clamp_flag <= r_clamp_flag;
    end
  end

  // Atomic swap of staging into the active bank, with the swap counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_active     <= '0;
      r_swap_count <= 8'd0;
    end else if (w_do_swap) begin
      r_active     <= r_staging;
      r_swap_count <= r_swap_count + 8'd1;
    end else begin
      r_active     <= r_active;
      r_swap_count <= r_swap_count;
    end
  end

  // Registered status: ack follows the swap cycle, busy tracks the upcoming state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack  <= w_do_swap;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign active_coef = r_active;
  assign busy        = r_busy;
  assign commit_ack  = r_ack;
  assign clamp_flag  = r_clamp_flag;
  assign swap_count  = r_swap_count;

endmodule
